// File: rtl/router_pkg.sv
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types and constants for the mesh router datapath.
//  Revision    : 1.0 - initial release with output-port merge types
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int NPORTS = 4;
    localparam int PTR_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_REL  = 2'd1,
        OUT_ACK = 2'd2,
        OUT_REL = 2'd3
    } out_state_t;

endpackage

`default_nettype wire

// File: rtl/output4to1_rr_arbiter4.sv
// ============================================================================
//  Module      : rr_arbiter4
//  Description : Four-way round-robin winner select; search begins after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter4
    import router_pkg::*;
(
    input  logic [NPORTS-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [PTR_W-1:0]  o_grant,
    output logic              o_valid
);

    logic [PTR_W-1:0] w_idx;

    // Offsets 1..4 from ptr; offset 4 wraps back to ptr itself, the lowest priority.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            w_idx = i_ptr + PTR_W'(k);
            if (!o_valid && i_req[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/output4to1.sv
// ============================================================================
//  Module      : output4to1
//  Description : Round-robin merge of four req/ack input channels into one
//                buffered req/ack output link.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output4to1
    import router_pkg::*;
#(
    parameter int          n        = 32,
    parameter int unsigned RR_RESET = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            in_req,
    output logic [NPORTS-1:0]            in_ack,
    input  logic [NPORTS-1:0][n-1:0]     in_data,
    output logic                         out_req,
    input  logic                         out_ack,
    output logic [n-1:0]                 out_data,
    output logic                         busy
);

    localparam logic [PTR_W-1:0] c_rr_reset = PTR_W'(RR_RESET);

    out_state_t         r_state;
    logic [NPORTS-1:0]  r_in_ack;
    logic               r_out_req;
    logic [n-1:0]       r_buf;
    logic [PTR_W-1:0]   r_gnt;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_busy;

    logic [PTR_W-1:0]   w_grant;
    logic               w_valid;

    rr_arbiter4 u_arb (
        .i_req   (in_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_in_ack  <= '0;
            r_out_req <= 1'b0;
            r_buf     <= '0;
            r_gnt     <= '0;
            r_ptr     <= c_rr_reset;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_buf    <= in_data[w_grant];
                        r_gnt    <= w_grant;
                        r_in_ack <= NPORTS'(1) << w_grant;
                        r_busy   <= 1'b1;
                        r_state  <= IN_REL;
                    end
                end
                IN_REL: begin
                    if (!in_req[r_gnt]) begin
                        r_in_ack  <= '0;
                        r_out_req <= 1'b1;
                        r_state   <= OUT_ACK;
                    end
                end
                OUT_ACK: begin
                    if (out_ack) begin
                        r_out_req <= 1'b0;
                        r_state   <= OUT_REL;
                    end
                end
                OUT_REL: begin
                    // Pointer advances only once the whole transfer has retired.
                    if (!out_ack) begin
                        r_ptr   <= r_gnt;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ack   = r_in_ack;
    assign out_req  = r_out_req;
    assign out_data = r_buf;
    assign busy     = r_busy;

endmodule

`default_nettype wire
